// File: rtl/ext_dev_pkg.sv
// Shared types and defaults for the clocked external I/O device model.
// The state enum and width helpers are used by the top and the record storage.
package ext_dev_pkg;

    typedef enum logic [2:0] {
        ARM,
        FIRE,
        SERVE,
        NEXT,
        HALT
    } ext_dev_state_e;

    localparam int DEF_WORD_SIZE     = 16;
    localparam int DEF_BURST_LEN     = 4;
    localparam int DEF_DEPTH         = 3;
    localparam int DEF_OFFSET_W      = 2;
    localparam int DEF_FIRE_INTERVAL = 1810;
    localparam int DEF_IRQ_TIMEOUT   = 10;
    localparam int DEF_NUM_FIRES     = 2;

    function automatic int rec_width(input int word_size, input int burst_len);
        return word_size * burst_len;
    endfunction

    // One shared down-counter serves both the arm interval and the irq timeout.
    function automatic int cnt_width(input int fire_interval, input int irq_timeout);
        int m;
        m = (fire_interval > irq_timeout) ? fire_interval : irq_timeout;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ext_dev_storage.sv
// DEPTH x record register array: one write port, one registered read port.
// Reads sample the array before the same-edge write lands (read-before-write).
module ext_dev_storage
    import ext_dev_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int OFFSET_W  = DEF_OFFSET_W
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         wr_en,
    input  logic [OFFSET_W-1:0]                          wr_addr,
    input  logic [rec_width(WORD_SIZE, BURST_LEN)-1:0]   wr_data,
    input  logic                                         rd_en,
    input  logic [OFFSET_W-1:0]                          rd_addr,
    output logic [rec_width(WORD_SIZE, BURST_LEN)-1:0]   rd_data
);

    localparam int REC_W = rec_width(WORD_SIZE, BURST_LEN);

    logic [DEPTH-1:0][REC_W-1:0] mem;
    logic [REC_W-1:0]            rd_sel;

    // Addresses >= DEPTH match no record, so such writes are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == OFFSET_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == OFFSET_W'(i)) rd_sel = mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rd_data <= '0;
        else if (rd_en) rd_data <= rd_sel;
    end

endmodule

// File: rtl/external_device_burst.sv
// Clocked external device: arms, raises interrupt, waits for ack or timeout,
// serves every record once to the DMA, then re-arms until NUM_FIRES is reached.
module external_device_burst
    import ext_dev_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int OFFSET_W      = DEF_OFFSET_W,
    parameter int FIRE_INTERVAL = DEF_FIRE_INTERVAL,
    parameter int IRQ_TIMEOUT   = DEF_IRQ_TIMEOUT,
    parameter int NUM_FIRES     = DEF_NUM_FIRES
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         ack,
    input  logic                                         rd_en,
    input  logic [OFFSET_W-1:0]                          offset,
    input  logic                                         wr_en,
    input  logic [OFFSET_W-1:0]                          wr_addr,
    input  logic [rec_width(WORD_SIZE, BURST_LEN)-1:0]   wr_data,
    output logic                                         interrupt,
    output logic [rec_width(WORD_SIZE, BURST_LEN)-1:0]   data,
    output logic                                         data_valid,
    output logic                                         rd_err,
    output logic                                         missed,
    output logic                                         done
);

    localparam int CNT_W = cnt_width(FIRE_INTERVAL, IRQ_TIMEOUT);
    localparam int FC_W  = (NUM_FIRES < 2) ? 1 : $clog2(NUM_FIRES + 1);

    localparam logic [CNT_W-1:0]  ARM_LOAD = CNT_W'(FIRE_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  IRQ_LOAD = CNT_W'(IRQ_TIMEOUT - 1);
    // One extra bit so DEPTH == 2**OFFSET_W does not truncate to zero.
    localparam logic [OFFSET_W:0] DEPTH_L  = (OFFSET_W + 1)'(DEPTH);

    ext_dev_state_e   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DEPTH-1:0] served_mask, mask_nxt;
    logic [FC_W-1:0]  fire_cnt, fc_nxt;
    logic             irq_nxt;
    logic             miss_set;
    logic             rd_legal;

    assign rd_legal = (state == SERVE) && rd_en && ({1'b0, offset} < DEPTH_L);
    assign done     = (state == HALT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = served_mask;
        fc_nxt    = fire_cnt;
        irq_nxt   = 1'b0;
        miss_set  = 1'b0;
        unique case (state)
            ARM: begin
                if (cnt == '0) begin
                    state_nxt = FIRE;
                    cnt_nxt   = IRQ_LOAD;
                    irq_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FIRE: begin
                // ack beats a timeout expiring on the same edge
                if (ack) begin
                    state_nxt = SERVE;
                end else if (cnt == '0) begin
                    state_nxt = NEXT;
                    miss_set  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    irq_nxt = 1'b1;
                end
            end
            SERVE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_legal && offset == OFFSET_W'(i)) mask_nxt[i] = 1'b1;
                end
                if (&mask_nxt) state_nxt = NEXT;
            end
            NEXT: begin
                mask_nxt = '0;
                fc_nxt   = fire_cnt + 1'b1;
                if ((NUM_FIRES != 0) && (fc_nxt == FC_W'(NUM_FIRES))) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = ARM;
                    cnt_nxt   = ARM_LOAD;
                end
            end
            HALT: state_nxt = HALT;
            default: begin
                state_nxt = ARM;
                cnt_nxt   = ARM_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARM;
            cnt         <= ARM_LOAD;
            served_mask <= '0;
            fire_cnt    <= '0;
            interrupt   <= 1'b0;
            data_valid  <= 1'b0;
            rd_err      <= 1'b0;
            missed      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            served_mask <= mask_nxt;
            fire_cnt    <= fc_nxt;
            interrupt   <= irq_nxt;
            data_valid  <= rd_legal;
            rd_err      <= rd_en & ~rd_legal;
            missed      <= missed | miss_set;
        end
    end

    ext_dev_storage #(
        .WORD_SIZE (WORD_SIZE),
        .BURST_LEN (BURST_LEN),
        .DEPTH     (DEPTH),
        .OFFSET_W  (OFFSET_W)
    ) u_storage (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_legal),
        .rd_addr (offset),
        .rd_data (data)
    );

endmodule

// File: tb/tb_external_device_burst.sv
// Directed bench for external_device_burst with a short arm interval and timeout.
module tb_external_device_burst;

    localparam logic [63:0] REC0   = 64'h0001_0002_0003_0004;
    localparam logic [63:0] REC1   = 64'h0001_0002_0003_0005;
    localparam logic [63:0] REC2   = 64'h0001_0002_0003_0006;
    localparam logic [63:0] NEWREC = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ack = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  offset = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        interrupt, data_valid, rd_err, missed, done;
    logic [63:0] data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    external_device_burst #(
        .WORD_SIZE(16), .BURST_LEN(4), .DEPTH(3), .OFFSET_W(2),
        .FIRE_INTERVAL(8), .IRQ_TIMEOUT(4), .NUM_FIRES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ack(ack), .rd_en(rd_en), .offset(offset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .interrupt(interrupt), .data(data), .data_valid(data_valid),
        .rd_err(rd_err), .missed(missed), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves reset_n released just after an edge, so the next edge is edge 1.
    task automatic apply_reset;
        reset_n = 1'b0; ack = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        offset = '0; wr_addr = '0; wr_data = '0;
        tick; tick;
        reset_n = 1'b1;
    endtask

    task automatic preload;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i);
            wr_data = (i == 0) ? REC0 : (i == 1) ? REC1 : REC2;
            tick;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        checks++;
        if ({interrupt, data_valid, rd_err, missed, done} !== 5'b0 || data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq/dv/err/miss/done=%b data=%h want 0", {interrupt, data_valid, rd_err, missed, done}, data);
        end
    endtask

    task automatic test_burst_read;
        apply_reset;
        preload;
        for (int e = 4; e <= 8; e++) begin
            tick;
            if (e == 7) begin
                checks++;
                if (interrupt !== 1'b0) begin errors++; $display("FAIL burst_irq_early: interrupt=%b want 0 at edge 7", interrupt); end
            end
            if (e == 8) begin
                checks++;
                if (interrupt !== 1'b1) begin errors++; $display("FAIL burst_irq_rise: interrupt=%b want 1 at edge 8", interrupt); end
            end
        end
        ack = 1'b1; tick; ack = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL burst_irq_ack: interrupt=%b want 0", interrupt); end
        rd_en = 1'b1; offset = 2'd2; tick;
        checks++;
        if (data_valid !== 1'b1 || data !== REC2) begin errors++; $display("FAIL burst_rd2: dv=%b data=%h want 1 %h", data_valid, data, REC2); end
        offset = 2'd0; tick;
        checks++;
        if (data_valid !== 1'b1 || data !== REC0) begin errors++; $display("FAIL burst_rd0: dv=%b data=%h want 1 %h", data_valid, data, REC0); end
        offset = 2'd1; tick; rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== REC1) begin errors++; $display("FAIL burst_rd1: dv=%b data=%h want 1 %h", data_valid, data, REC1); end
        for (int k = 1; k <= 9; k++) begin
            tick;
            if (k == 1) begin
                checks++;
                if (data_valid !== 1'b0) begin errors++; $display("FAIL burst_dv_pulse: dv=%b want 0", data_valid); end
            end
            if (k == 2) begin rd_en = 1'b1; offset = 2'd0; end
            if (k == 3) begin
                rd_en = 1'b0;
                checks++;
                if (rd_err !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL arm_rd_err: err=%b dv=%b want 1 0", rd_err, data_valid); end
            end
            if (k == 8) begin
                checks++;
                if (interrupt !== 1'b0) begin errors++; $display("FAIL rearm_irq_early: interrupt=%b want 0", interrupt); end
            end
            if (k == 9) begin
                checks++;
                if (interrupt !== 1'b1) begin errors++; $display("FAIL rearm_irq_rise: interrupt=%b want 1", interrupt); end
            end
        end
        ack = 1'b1; tick; ack = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin offset = 2'(i); tick; end
        rd_en = 1'b0;
        checks++;
        if (data !== REC2 || done !== 1'b0) begin errors++; $display("FAIL second_burst: data=%h done=%b want %h 0", data, done, REC2); end
        tick;
        checks++;
        if (done !== 1'b1 || missed !== 1'b0) begin errors++; $display("FAIL burst_done: done=%b missed=%b want 1 0", done, missed); end
        rd_en = 1'b1; ack = 1'b1; offset = 2'd0; tick; rd_en = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL halt_rd_err: err=%b dv=%b want 1 0", rd_err, data_valid); end
        tick; tick; ack = 1'b0;
        checks++;
        if (interrupt !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL halt_idle: irq=%b done=%b want 0 1", interrupt, done); end
    endtask

    task automatic test_timeout;
        int hi;
        apply_reset;
        hi = 0;
        for (int e = 1; e <= 12; e++) begin
            tick;
            if (interrupt) hi++;
            if (e == 8) begin
                checks++;
                if (interrupt !== 1'b1) begin errors++; $display("FAIL to_irq_rise: interrupt=%b want 1", interrupt); end
            end
        end
        checks++;
        if (hi != 4 || interrupt !== 1'b0 || missed !== 1'b1) begin
            errors++; $display("FAIL to_first: high_cycles=%0d irq=%b missed=%b want 4 0 1", hi, interrupt, missed);
        end
        hi = 0;
        for (int e = 13; e <= 26; e++) begin
            tick;
            if (interrupt) hi++;
            if (e == 21) begin
                checks++;
                if (interrupt !== 1'b1) begin errors++; $display("FAIL to_second_rise: interrupt=%b want 1 at edge 21", interrupt); end
            end
            if (e == 25) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL to_done_early: done=%b want 0", done); end
            end
        end
        checks++;
        if (hi != 4 || done !== 1'b1 || missed !== 1'b1) begin
            errors++; $display("FAIL to_second: high_cycles=%0d done=%b missed=%b want 4 1 1", hi, done, missed);
        end
        hi = 0;
        for (int e = 0; e < 12; e++) begin tick; if (interrupt) hi++; end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL to_halt_quiet: high_cycles=%0d want 0", hi); end
    endtask

    task automatic test_rd_err;
        logic seen;
        apply_reset;
        preload;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick;
            if (interrupt) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rd_err_irq_wait: interrupt never rose, want 1"); end
        ack = 1'b1; tick; ack = 1'b0;
        rd_en = 1'b1; offset = 2'd1; tick;
        checks++;
        if (data_valid !== 1'b1 || data !== REC1) begin errors++; $display("FAIL serve_rd1: dv=%b data=%h want 1 %h", data_valid, data, REC1); end
        offset = 2'd3; tick;
        checks++;
        if (rd_err !== 1'b1 || data_valid !== 1'b0 || data !== REC1) begin
            errors++; $display("FAIL serve_oob: err=%b dv=%b data=%h want 1 0 %h", rd_err, data_valid, data, REC1);
        end
        offset = 2'd1; tick;
        checks++;
        if (rd_err !== 1'b0 || data_valid !== 1'b1 || data !== REC1) begin
            errors++; $display("FAIL serve_reread: err=%b dv=%b data=%h want 0 1 %h", rd_err, data_valid, data, REC1);
        end
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = NEWREC; tick; wr_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== REC1) begin errors++; $display("FAIL rbw_old: dv=%b data=%h want 1 %h", data_valid, data, REC1); end
        tick;
        checks++;
        if (data_valid !== 1'b1 || data !== NEWREC) begin errors++; $display("FAIL rbw_new: dv=%b data=%h want 1 %h", data_valid, data, NEWREC); end
        offset = 2'd0; tick; rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== REC0) begin errors++; $display("FAIL serve_still: dv=%b data=%h want 1 %h", data_valid, data, REC0); end
    endtask

    task automatic test_ack_late;
        apply_reset;
        preload;
        for (int e = 4; e <= 11; e++) tick;
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL late_irq_4th: interrupt=%b want 1", interrupt); end
        ack = 1'b1; tick; ack = 1'b0;
        checks++;
        if (interrupt !== 1'b0 || missed !== 1'b0) begin errors++; $display("FAIL late_ack: irq=%b missed=%b want 0 0", interrupt, missed); end
        rd_en = 1'b1; offset = 2'd0; tick; rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== REC0) begin errors++; $display("FAIL late_serve: dv=%b data=%h want 1 %h", data_valid, data, REC0); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({interrupt, data_valid, rd_err, missed, done} !== 5'b0 || data !== 64'h0) begin
            errors++; $display("FAIL async_reset: irq/dv/err/miss/done=%b data=%h want 0", {interrupt, data_valid, rd_err, missed, done}, data);
        end
        tick;
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick;
            if (e == 7) begin
                checks++;
                if (interrupt !== 1'b0) begin errors++; $display("FAIL post_reset_early: interrupt=%b want 0", interrupt); end
            end
        end
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL post_reset_irq: interrupt=%b want 1 at edge 8", interrupt); end
        ack = 1'b1; tick; ack = 1'b0;
        rd_en = 1'b1; offset = 2'd0; tick; rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data !== 64'h0) begin errors++; $display("FAIL storage_cleared: dv=%b data=%h want 1 0", data_valid, data); end
    endtask

    initial begin
        test_reset;
        test_burst_read;
        test_timeout;
        test_rd_err;
        test_ack_late;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
